// File: rtl/soc_system_lfsr_sequence_gen.sv
// Galois LFSR sequence generator with an Avalon-MM CSR slave and an Avalon-ST source.
// The state advances only on an accepted beat or on a CSR single-step strobe.
module soc_system_lfsr_sequence_gen #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = 32'h80200003,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h3F60FF91
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] st_data,
  output logic             st_valid,
  input  logic             st_ready
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [31:0]      r_count;
  logic             r_run;
  logic             r_lockup;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_status;
  logic             w_step;
  logic             w_load;
  logic             w_seed_zero;
  logic [WIDTH-1:0] w_lfsr_nxt;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr && (address == 2'd0);
  assign w_wr_status = w_wr && (address == 2'd1);
  assign w_load      = (r_state == StLoad);
  assign w_seed_zero = (seed_in == '0);
  assign w_lfsr_nxt  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  assign st_valid = (r_state == StRun);
  assign st_data  = r_lfsr;

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_wr_ctrl) begin
          if (writedata[1])      w_state_nxt = StLoad;
          else if (writedata[0]) w_state_nxt = StRun;
          else if (writedata[2]) w_step      = 1'b1;
        end
      end
      StLoad: begin
        w_state_nxt = r_run ? StRun : StIdle;
      end
      StRun: begin
        // A handshake still steps even when the same write leaves RUN.
        w_step = st_ready;
        if (w_wr_ctrl) begin
          if (writedata[1])       w_state_nxt = StLoad;
          else if (!writedata[0]) w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_lfsr   <= DEFAULT_SEED;
      r_count  <= '0;
      r_run    <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_ctrl) r_run <= writedata[0];
      if (w_load) begin
        r_lfsr  <= w_seed_zero ? DEFAULT_SEED : seed_in;
        r_count <= '0;
      end else if (w_step) begin
        r_lfsr  <= w_lfsr_nxt;
        r_count <= r_count + 32'd1;
      end
      if (w_load && w_seed_zero)            r_lockup <= 1'b1;
      else if (w_wr_status && writedata[1]) r_lockup <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = {31'd0, r_run};
      2'd1: readdata = {30'd0, r_lockup, (r_state == StRun)};
      2'd2: readdata = 32'(r_lfsr);
      2'd3: readdata = r_count;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_lfsr_sequence_gen.sv
// Scoreboard bench: expected stream beats are queued by the stimulus and checked by a monitor.
module tb_soc_system_lfsr_sequence_gen;

  logic        clk;
  logic        reset;
  logic [31:0] seed_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] Dflt = 32'h3F60FF91;

  soc_system_lfsr_sequence_gen dut (
    .clk       (clk),
    .reset     (reset),
    .seed_in   (seed_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .st_data   (st_data),
    .st_valid  (st_valid),
    .st_ready  (st_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic csr_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs settle 1ns after posedge; a beat seen here is accepted on the next posedge.
  always @(negedge clk) begin
    if (!reset && st_valid && st_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", st_data, 32'hxxxxxxxx);
      end else begin
        chk("beat", st_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; seed_in = 32'h0; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 32'h0; st_ready = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(1);

    // T1 reset state
    csr_chk("t1_state", 2'd2, Dflt);
    csr_chk("t1_count", 2'd3, 32'h0);
    csr_chk("t1_status", 2'd1, 32'h0);
    chk("t1_valid", {31'd0, st_valid}, 32'h0);
    chk("t1_data", st_data, Dflt);

    // T5 single step from IDLE
    csr_wr(2'd0, 32'h4);
    csr_chk("t5_state", 2'd2, 32'h9F907FCB);
    csr_chk("t5_count", 2'd3, 32'h1);
    chk("t5_valid", {31'd0, st_valid}, 32'h0);

    // T2 load seed 1 and run
    seed_in = 32'h1;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h80200003);
    exp_q.push_back(32'hC0300002);
    exp_q.push_back(32'h60180001);
    exp_q.push_back(32'hB02C0003);
    exp_q.push_back(32'hD8360002);
    exp_q.push_back(32'h6C1B0001);
    csr_wr(2'd0, 32'h3);
    chk("t2_load_valid", {31'd0, st_valid}, 32'h0);
    cycles(1);
    seed_in = 32'hDEADBEEF;
    chk("t2_run_valid", {31'd0, st_valid}, 32'h1);
    st_ready = 1'b1;
    cycles(3);
    st_ready = 1'b0;
    csr_chk("t2_count", 2'd3, 32'h3);
    csr_chk("t2_status", 2'd1, 32'h1);

    // T3 backpressure holds data and count
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", st_data, 32'h60180001);
      chk("t3_hold_valid", {31'd0, st_valid}, 32'h1);
      csr_chk("t3_hold_count", 2'd3, 32'h3);
      cycles(1);
    end
    st_ready = 1'b1;
    cycles(4);
    st_ready = 1'b0;
    csr_chk("t3_count", 2'd3, 32'h7);
    csr_chk("t3_state", 2'd2, 32'hB62D8003);

    // Clear run
    csr_wr(2'd0, 32'h0);
    chk("stop_valid", {31'd0, st_valid}, 32'h0);
    csr_chk("stop_status", 2'd1, 32'h0);

    // T4 zero seed substitutes the default and flags lockup
    seed_in = 32'h0;
    csr_wr(2'd0, 32'h2);
    cycles(1);
    csr_chk("t4_state", 2'd2, Dflt);
    csr_chk("t4_count", 2'd3, 32'h0);
    csr_chk("t4_status", 2'd1, 32'h2);
    chk("t4_valid", {31'd0, st_valid}, 32'h0);
    csr_wr(2'd1, 32'h2);
    csr_chk("t4_w1c", 2'd1, 32'h0);

    // T6 count wrap, then reset mid-run
    seed_in = 32'h1;
    csr_wr(2'd0, 32'h3);
    cycles(1);
    @(negedge clk);
    force dut.r_count = 32'hFFFFFFFF;
    #1;
    release dut.r_count;
    @(posedge clk); #1;
    exp_q.push_back(32'h00000001);
    st_ready = 1'b1;
    cycles(1);
    st_ready = 1'b0;
    csr_chk("t6_wrap_count", 2'd3, 32'h0);
    csr_chk("t6_state", 2'd2, 32'h80200003);
    chk("t6_pre_valid", {31'd0, st_valid}, 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, st_valid}, 32'h0);
    chk("t6_rst_data", st_data, Dflt);
    csr_chk("t6_rst_count", 2'd3, 32'h0);
    csr_chk("t6_rst_status", 2'd1, 32'h0);
    csr_chk("t6_rst_ctrl", 2'd0, 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(2);
    chk("t6_post_valid", {31'd0, st_valid}, 32'h0);

    chk("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
